// File: rtl/bch_pkg.sv
// Shared GF(2^M) arithmetic and FSM state type for the parallel Chien search.
package bch_pkg;

  localparam int GF_MAX_M = 16;
  typedef logic [GF_MAX_M-1:0] gf_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

  // Shift-and-add multiply reduced by prim; operands must be below 2^m, m < GF_MAX_M.
  function automatic gf_t gf_mul(input gf_t a, input gf_t b, input gf_t prim, input int m);
    gf_t acc;
    gf_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) acc ^= sh;
      sh = sh << 1;
      if (sh[m]) sh ^= prim;
    end
    return acc;
  endfunction

  // alpha^(e mod 2^m-1); negative exponents wrap onto the multiplicative group.
  function automatic gf_t alpha_pow(input int e, input gf_t prim, input int m);
    int  q;
    int  r;
    gf_t v;
    q = (1 << m) - 1;
    r = e % q;
    if (r < 0) r += q;
    v = gf_t'(1);
    for (int i = 0; i < r; i++) v = gf_mul(v, gf_t'(2), prim, m);
    return v;
  endfunction

endpackage

// File: rtl/bch_chien_lane.sv
// One Chien lane: evaluates sum_j R_j * alpha^(-j*LANE) and flags a zero sum.
module bch_chien_lane
  import bch_pkg::*;
#(
  parameter int         M    = 4,
  parameter int         T    = 3,
  parameter logic [M:0] PRIM = 5'b10011,
  parameter int         LANE = 0
) (
  input  logic [T*M-1:0] r,
  output logic           zero
);

  logic [M-1:0] term [T];
  logic [M-1:0] acc;

  for (genvar j = 0; j < T; j++) begin : g_term
    localparam gf_t K = alpha_pow(-j * LANE, gf_t'(PRIM), M);
    assign term[j] = M'(gf_mul(gf_t'(r[j*M +: M]), K, gf_t'(PRIM), M));
  end

  always_comb begin
    acc = '0;
    for (int j = 0; j < T; j++) acc ^= term[j];
  end

  assign zero = (acc == '0);

endmodule

// File: rtl/bch_chien_par.sv
// Parallel Chien search: P positions per cycle, then a finalise cycle that
// settles the fail verdict before the result is presented.
module bch_chien_par
  import bch_pkg::*;
#(
  parameter int         M    = 4,
  parameter int         N    = 15,
  parameter int         T    = 3,
  parameter int         P    = 5,
  parameter logic [M:0] PRIM = 5'b10011
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           received,
  input  logic [T*M-1:0]         locator,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           codeword,
  output logic [$clog2(N+1)-1:0] err_cnt,
  output logic                   fail
);

  localparam int C  = (N + P - 1) / P;
  localparam int CW = $clog2(N + 1);
  localparam int KW = (C > 1) ? $clog2(C + 1) : 1;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q;
  logic [T*M-1:0] r_q, r_step;
  logic [N-1:0]   recv_q, err_q, err_d;
  logic [CW-1:0]  cnt_q, deg_q, deg_in, hit_cnt;
  logic           lam0_zero_q, fail_q;
  logic [P-1:0]   zero, hits;
  logic           active, last;

  for (genvar j = 0; j < T; j++) begin : g_step
    localparam gf_t K = alpha_pow(-j * P, gf_t'(PRIM), M);
    assign r_step[j*M +: M] = M'(gf_mul(gf_t'(r_q[j*M +: M]), K, gf_t'(PRIM), M));
  end

  assign active = (state_q == ST_ITER) && (k_q < KW'(C));
  assign last   = (k_q == KW'(C - 1));

  // Lanes past the end of the word exist only in the last evaluation cycle.
  for (genvar p = 0; p < P; p++) begin : g_lane
    localparam logic TAIL = ((C - 1) * P + p) >= N;
    bch_chien_lane #(.M(M), .T(T), .PRIM(PRIM), .LANE(p)) u_lane (
      .r    (r_q),
      .zero (zero[p])
    );
    assign hits[p] = active & zero[p] & ~(last & TAIL);
  end

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit_cnt = '0;
    for (int p = 0; p < P; p++) hit_cnt += CW'(hits[p]);
    deg_in = '0;
    for (int j = 1; j < T; j++) if (locator[j*M +: M] != '0) deg_in = CW'(j);
  end

  // Hits from masked lanes are zero, so bits shifted beyond N carry no information.
  assign err_d = err_q | (N'(hits) << (k_q * P));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_ITER;
      end
      ST_ITER: if (k_q == KW'(C)) state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      r_q         <= '0;
      recv_q      <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      deg_q       <= '0;
      lam0_zero_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          recv_q      <= received;
          r_q         <= locator;
          err_q       <= '0;
          cnt_q       <= '0;
          k_q         <= '0;
          deg_q       <= deg_in;
          lam0_zero_q <= (locator[M-1:0] == '0);
          fail_q      <= 1'b0;
        end
        ST_ITER: begin
          k_q <= k_q + 1'b1;
          if (active) begin
            r_q   <= r_step;
            err_q <= err_d;
            cnt_q <= cnt_q + hit_cnt;
          end else begin
            fail_q <= lam0_zero_q || (cnt_q != deg_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign codeword = recv_q ^ err_q;
  assign err_cnt  = cnt_q;
  assign fail     = fail_q;

endmodule
